mac_rx_framer: RTL and testbench



---
 rtl/mac_pkg.sv | 28 ++
 rtl/mac_crc32.sv | 25 ++
 rtl/mac_rx_framer.sv | 173 +++++++++++++++++
 tb/tb_mac_rx_framer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants, state encoding and byte-wide CRC-32 step for the MAC datapaths.
package mac_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StPayload,
        StDrop
    } rx_state_e;

    // Reflected CRC-32 over one byte, LSB first, no final inversion.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_crc32.sv
// Registered 8-bit-parallel CRC-32 accumulator; init takes priority over en.
module mac_crc32
    import mac_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || init) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc32_d8(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mac_rx_framer.sv
// Ethernet RX framer: strips preamble/SFD, delays the stream by the FCS length,
// checks CRC-32 and length, and marks the last byte with the frame verdict.
module mac_rx_framer
    import mac_pkg::*;
#(
    parameter int unsigned EOF_GAP   = 8,
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx_data_valid,
    input  logic       rx_data_error,
    input  logic [7:0] rx_data,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       m_err,
    output logic       stat_frame_ok,
    output logic       stat_crc_err,
    output logic       stat_len_err
);

    localparam int unsigned GapW  = $clog2(EOF_GAP) + 1;
    localparam int unsigned Depth = 5;

    rx_state_e        state_q, state_d;
    logic [GapW-1:0]  gap_q;
    logic [4:0][7:0]  hold_q;
    logic [2:0]       fill_q;
    logic [15:0]      len_q;
    logic             phy_err_q;
    logic [31:0]      crc;

    logic [7:0] m_data_q, m_data_d;
    logic       m_valid_q, m_valid_d;
    logic       m_last_q, m_last_d;
    logic       m_err_q, m_err_d;
    logic       ok_q, ok_d;
    logic       crc_err_q, crc_err_d;
    logic       len_err_q, len_err_d;

    logic sfd_hit;
    logic pay_byte;
    logic eof_det;
    logic hold_full;
    logic crc_bad;
    logic len_bad;

    assign sfd_hit   = rx_data_valid && (rx_data == SFD_BYTE)
                       && ((state_q == StIdle) || (state_q == StPreamble));
    assign pay_byte  = rx_data_valid && (state_q == StPayload);
    assign eof_det   = !rx_data_valid && (gap_q == GapW'(EOF_GAP - 1)) && (state_q != StIdle);
    assign hold_full = (fill_q == 3'(Depth));
    assign crc_bad   = (crc != CRC_RESIDUE);
    assign len_bad   = (len_q < 16'(MIN_FRAME)) || (len_q > 16'(MAX_FRAME));

    mac_crc32 u_crc (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .init    (sfd_hit),
        .en      (pay_byte),
        .data    (rx_data),
        .crc     (crc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rx_data_valid) begin
                    if (rx_data == PREAMBLE_BYTE) state_d = StPreamble;
                    else if (rx_data == SFD_BYTE) state_d = StPayload;
                    else                          state_d = StDrop;
                end
            end
            StPreamble: begin
                if (rx_data_valid) begin
                    if (rx_data == SFD_BYTE)           state_d = StPayload;
                    else if (rx_data != PREAMBLE_BYTE) state_d = StDrop;
                end else if (eof_det) begin
                    state_d = StIdle;
                end
            end
            StPayload: if (eof_det) state_d = StIdle;
            StDrop:    if (eof_det) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            gap_q     <= '0;
            hold_q    <= '0;
            fill_q    <= '0;
            len_q     <= '0;
            phy_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rx_data_valid) begin
                gap_q <= '0;
            end else if (gap_q != GapW'(EOF_GAP - 1)) begin
                gap_q <= gap_q + 1'b1;
            end
            if (sfd_hit) begin
                fill_q    <= '0;
                len_q     <= '0;
                phy_err_q <= 1'b0;
            end else if (pay_byte) begin
                hold_q <= {hold_q[3:0], rx_data};
                if (!hold_full)          fill_q    <= fill_q + 3'd1;
                if (len_q != 16'hFFFF)   len_q     <= len_q + 16'd1;
                if (rx_data_error)       phy_err_q <= 1'b1;
            end
        end
    end

    // The four newest held bytes are the FCS, so only hold_q[4] ever leaves.
    always_comb begin
        m_data_d  = 8'd0;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        m_err_d   = 1'b0;
        ok_d      = 1'b0;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        if (pay_byte && hold_full) begin
            m_valid_d = 1'b1;
            m_data_d  = hold_q[4];
        end
        if (eof_det && (state_q == StPayload)) begin
            len_err_d = len_bad;
            crc_err_d = !len_bad && (crc_bad || phy_err_q);
            ok_d      = !len_bad && !crc_bad && !phy_err_q;
            if (hold_full) begin
                m_valid_d = 1'b1;
                m_last_d  = 1'b1;
                m_data_d  = hold_q[4];
                m_err_d   = len_bad || crc_bad || phy_err_q;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            m_data_q  <= 8'd0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_err_q   <= 1'b0;
            ok_q      <= 1'b0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_err_q   <= m_err_d;
            ok_q      <= ok_d;
            crc_err_q <= crc_err_d;
            len_err_q <= len_err_d;
        end
    end

    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign m_last        = m_last_q;
    assign m_err         = m_err_q;
    assign stat_frame_ok = ok_q;
    assign stat_crc_err  = crc_err_q;
    assign stat_len_err  = len_err_q;

endmodule

// File: tb/tb_mac_rx_framer.sv
// Directed bench for mac_rx_framer: table of frame cases plus hand-written corner sequences.
module tb_mac_rx_framer;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rx_data_valid = 1'b0;
    logic       rx_data_error = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic [7:0] m_data;
    logic       m_valid, m_last, m_err;
    logic       stat_frame_ok, stat_crc_err, stat_len_err;

    always #5 sys_clk = ~sys_clk;

    mac_rx_framer #(
        .EOF_GAP   (8),
        .MIN_FRAME (64),
        .MAX_FRAME (1518)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .rx_data_valid (rx_data_valid),
        .rx_data_error (rx_data_error),
        .rx_data       (rx_data),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_err         (m_err),
        .stat_frame_ok (stat_frame_ok),
        .stat_crc_err  (stat_crc_err),
        .stat_len_err  (stat_len_err)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] out_q[$];
    logic [7:0] exp_q[$];
    int         last_cnt, last_pos, ok_cnt, crc_cnt, len_cnt;
    logic       last_err;

    always @(negedge sys_clk) begin
        if (m_valid) begin
            out_q.push_back(m_data);
            if (m_last) begin
                last_cnt++;
                last_pos = out_q.size();
                last_err = m_err;
            end
        end
        if (stat_frame_ok) ok_cnt++;
        if (stat_crc_err)  crc_cnt++;
        if (stat_len_err)  len_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic clear_mon();
        out_q.delete();
        exp_q.delete();
        last_cnt = 0; last_pos = 0; last_err = 1'b0;
        ok_cnt = 0; crc_cnt = 0; len_cnt = 0;
    endtask

    // Bit-serial reference CRC, written independently of the DUT's byte step.
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk); #1;
            rx_data_valid = 1'b0;
            rx_data_error = 1'b0;
            rx_data       = 8'd0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e, input int spacing);
        @(posedge sys_clk); #1;
        rx_data_valid = 1'b1;
        rx_data_error = e;
        rx_data       = b;
        for (int k = 1; k < spacing; k++) begin
            @(posedge sys_clk); #1;
            rx_data_valid = 1'b0;
            rx_data_error = 1'b0;
        end
    endtask

    // Sends preamble, SFD, payload 00.. and a correct FCS; optionally corrupts one byte
    // after the FCS is computed or flags a PHY error. Fills exp_q with the payload sent.
    task automatic send_frame(input int pay_len, input int corrupt_idx, input int err_idx,
                              input int n_pre, input int spacing, input bit tail_gap);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n_pre; i++) send_byte(8'h55, 1'b0, spacing);
        send_byte(8'hD5, 1'b0, spacing);
        for (int i = 0; i < pay_len; i++) begin
            b = 8'(i);
            c = ref_crc(c, b);
            if (i == corrupt_idx) b = b ^ 8'h01;
            exp_q.push_back(b);
            send_byte(b, (i == err_idx), spacing);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) begin
            b = c[8*i +: 8];
            send_byte(b, 1'b0, spacing);
        end
        if (tail_gap) idle(16);
    endtask

    task automatic check_frame(input string tag, input int exp_out, input int exp_err,
                               input int exp_ok, input int exp_crc, input int exp_len);
        int mism;
        mism = 0;
        check({tag, " out_count"}, out_q.size(), exp_out);
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            if (out_q[i] !== exp_q[i]) mism++;
        end
        if (exp_out > 0) begin
            check({tag, " data_mismatches"}, mism, 0);
            check({tag, " last_pos"}, last_pos, exp_out);
            check({tag, " last_err"}, int'(last_err), exp_err);
        end
        check({tag, " last_count"}, last_cnt, (exp_out > 0) ? 1 : 0);
        check({tag, " stat_ok"}, ok_cnt, exp_ok);
        check({tag, " stat_crc"}, crc_cnt, exp_crc);
        check({tag, " stat_len"}, len_cnt, exp_len);
    endtask

    typedef struct {
        int pay_len;
        int corrupt_idx;
        int err_idx;
        int n_pre;
        int spacing;
        int exp_out;
        int exp_err;
        int exp_ok;
        int exp_crc;
        int exp_len;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // pay, corrupt, phyerr, pre, spacing | out, err, ok, crc, len
        vecs[0] = '{60, -1, -1, 7, 1, 60, 1'b0, 1, 0, 0};  // good frame
        vecs[1] = '{60, 16, -1, 7, 1, 60, 1'b1, 0, 1, 0};  // 0x10 -> 0x11
        vecs[2] = '{40, -1, -1, 7, 1, 40, 1'b1, 0, 0, 1};  // 44 B runt
        vecs[3] = '{60, -1, 20, 7, 1, 60, 1'b1, 0, 1, 0};  // PHY error
        vecs[4] = '{60, -1, -1, 7, 3, 60, 1'b0, 1, 0, 0};  // valid 1-in-3
        vecs[5] = '{60, -1, -1, 0, 1, 60, 1'b0, 1, 0, 0};  // SFD only

        clear_mon();
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst m_valid", int'(m_valid), 0);
        check("rst m_last", int'(m_last), 0);
        check("rst m_err", int'(m_err), 0);
        check("rst m_data", int'(m_data), 0);
        check("rst stat_ok", int'(stat_frame_ok), 0);
        check("rst stat_crc", int'(stat_crc_err), 0);
        check("rst stat_len", int'(stat_len_err), 0);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            send_frame(vecs[v].pay_len, vecs[v].corrupt_idx, vecs[v].err_idx,
                       vecs[v].n_pre, vecs[v].spacing, 1'b1);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_out, vecs[v].exp_err,
                        vecs[v].exp_ok, vecs[v].exp_crc, vecs[v].exp_len);
        end

        // 3-byte frame: nothing leaves the hold buffer, only the length stat fires.
        clear_mon();
        send_byte(8'h55, 1'b0, 1);
        send_byte(8'hD5, 1'b0, 1);
        send_byte(8'hA1, 1'b0, 1);
        send_byte(8'hA2, 1'b0, 1);
        send_byte(8'hA3, 1'b0, 1);
        idle(16);
        check_frame("tiny", 0, 0, 0, 0, 1);

        // Bad preamble: the rest of the burst (even SFD-looking bytes) is dropped.
        clear_mon();
        send_byte(8'h55, 1'b0, 1);
        send_byte(8'h55, 1'b0, 1);
        send_byte(8'h12, 1'b0, 1);
        for (int i = 0; i < 20; i++) send_byte((i % 2) ? 8'hD5 : 8'h55, 1'b0, 1);
        idle(16);
        check_frame("badpre", 0, 0, 0, 0, 0);
        clear_mon();
        send_frame(60, -1, -1, 7, 1, 1'b1);
        check_frame("after_badpre", 60, 0, 1, 0, 0);

        // Reset in the middle of a payload that is already streaming.
        clear_mon();
        send_frame(30, -1, -1, 7, 1, 1'b0);
        @(posedge sys_clk); #1;
        rx_data_valid = 1'b0;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("midrst streamed", (out_q.size() > 0) ? 1 : 0, 1);
        check("midrst m_valid", int'(m_valid), 0);
        check("midrst m_last", int'(m_last), 0);
        check("midrst m_data", int'(m_data), 0);
        clear_mon();
        idle(16);
        check_frame("midrst_tail", 0, 0, 0, 0, 0);
        clear_mon();
        send_frame(60, -1, -1, 7, 1, 1'b1);
        check_frame("after_rst", 60, 0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
